// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared ChaCha round-controller state encoding and step constants
//
// Provides:
//   state_t         round controller FSM encoding (IDLE, CALC, SHIFT, ADD, FIN)
//   CALC_LAST_STEP  last quarter-round step index in a half-round
//   SHIFT_LAST_IDX  last cycle index of the six-cycle row-rotate phase
//   HALF_W          width of the half-round counter (covers ROUNDS up to 30)
//   shift_step()    row select for a given row-rotate cycle and half-round parity
package chacha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ADD   = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam int          STEP_W         = 2;
    localparam logic [1:0]  CALC_LAST_STEP = 2'd3;
    localparam int          SHIFT_CYCLES   = 6;
    localparam logic [2:0]  SHIFT_LAST_IDX = 3'(SHIFT_CYCLES - 1);
    localparam int          HALF_W         = 5;

    // The datapath rotates one row by one word per cycle. After a column
    // half-round rows 1,2,3 are rotated 1,2,3 times to line up the diagonals;
    // after a diagonal half-round they are rotated 3,2,1 times, which completes
    // a full four-word turn and restores column alignment.
    function automatic logic [1:0] shift_step(input logic [2:0] idx, input logic diag);
        logic [1:0] row;
        if (!diag) begin
            if (idx == 3'd0)     row = 2'd1;
            else if (idx < 3'd3) row = 2'd2;
            else                 row = 2'd3;
        end else begin
            if (idx < 3'd3)      row = 2'd1;
            else if (idx < 3'd5) row = 2'd2;
            else                 row = 2'd3;
        end
        return row;
    endfunction

endpackage

// File: rtl/round_ctrl.sv
// rtl/round_ctrl.sv - ChaCha block round sequencer driving a word-serial datapath
//
// Parameters:
//   ROUNDS     number of ChaCha rounds (half-rounds executed), even, 2..30
// Optional feature:
//   ROUND_CTRL_ABORT_EN  adds input abort; abort while busy abandons the block
//                        and resets the datapath, abort in IDLE acts as clear
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               single-cycle block request (IDLE only)
//   clear               datapath reinitialise request (IDLE only)
//   host_we, host_addr  host byte write strobe and address
//   dp_rst_n            datapath synchronous reset (low during reset/clear/abort)
//   write               datapath write strobe (host write passed through in IDLE)
//   calc                quarter-round step enable
//   shift               row-rotate enable
//   add_back            feed-forward enable
//   step                quarter-round step / row select
//   addr_out            datapath byte address (host_addr passthrough)
//   busy                computation in progress
//   done                one-cycle completion pulse
module round_ctrl
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ROUND_CTRL_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic              clear,
    input  logic              host_we,
    input  logic [5:0]        host_addr,
    output logic              dp_rst_n,
    output logic              write,
    output logic              calc,
    output logic              shift,
    output logic              add_back,
    output logic [STEP_W-1:0] step,
    output logic [5:0]        addr_out,
    output logic              busy,
    output logic              done
);

    localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(ROUNDS);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   calc_q, calc_d;
    logic [2:0]          sidx_q, sidx_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [HALF_W-1:0]   half_next;
    logic                abort_req;

`ifdef ROUND_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign half_next = half_q + 1'b1;
    assign addr_out  = host_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            calc_q  <= '0;
            sidx_q  <= '0;
            half_q  <= '0;
        end else begin
            state_q <= state_d;
            calc_q  <= calc_d;
            sidx_q  <= sidx_d;
            half_q  <= half_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        calc_d   = calc_q;
        sidx_d   = sidx_q;
        half_d   = half_q;
        dp_rst_n = 1'b1;
        write    = 1'b0;
        calc     = 1'b0;
        shift    = 1'b0;
        add_back = 1'b0;
        step     = '0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // start beats clear/abort, which beat a host write
                if (start) begin
                    state_d = ST_CALC;
                    calc_d  = '0;
                    sidx_d  = '0;
                    half_d  = '0;
                end else if (clear || abort_req) begin
                    dp_rst_n = 1'b0;
                end else begin
                    write = host_we;
                end
            end

            ST_CALC: begin
                busy = 1'b1;
                calc = 1'b1;
                step = calc_q;
                if (calc_q == CALC_LAST_STEP) begin
                    state_d = ST_SHIFT;
                    calc_d  = '0;
                    sidx_d  = '0;
                end else begin
                    calc_d = calc_q + 1'b1;
                end
            end

            ST_SHIFT: begin
                busy  = 1'b1;
                shift = 1'b1;
                // half-round parity: even = column round, odd = diagonal round
                step  = shift_step(sidx_q, half_q[0]);
                if (sidx_q == SHIFT_LAST_IDX) begin
                    sidx_d = '0;
                    half_d = half_next;
                    state_d = (half_next == LAST_HALF) ? ST_ADD : ST_CALC;
                end else begin
                    sidx_d = sidx_q + 1'b1;
                end
            end

            ST_ADD: begin
                busy     = 1'b1;
                add_back = 1'b1;
                state_d  = ST_FIN;
            end

            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abandon an in-flight block: the datapath state is now meaningless,
        // so reset it alongside the return to IDLE.
        if (abort_req && busy) begin
            state_d  = ST_IDLE;
            calc_d   = '0;
            sidx_d   = '0;
            half_d   = '0;
            dp_rst_n = 1'b0;
        end

        if (!rst_n) begin
            dp_rst_n = 1'b0;
            write    = 1'b0;
            calc     = 1'b0;
            shift    = 1'b0;
            add_back = 1'b0;
            step     = '0;
            busy     = 1'b0;
            done     = 1'b0;
        end
    end

endmodule

// File: tb/tb_round_ctrl.sv
// tb/tb_round_ctrl.sv - self-checking bench for round_ctrl against a cycle-index model
module tb_round_ctrl;

    localparam int ROUNDS = 20;
    localparam int R10    = 10 * ROUNDS;

    logic       clk = 1'b0;
    logic       rst_n, start, clear, host_we;
    logic [5:0] host_addr;
`ifdef ROUND_CTRL_ABORT_EN
    logic       abort;
`endif
    logic       dp_rst_n, write, calc, shift, add_back, busy, done;
    logic [1:0] step;
    logic [5:0] addr_out;

    round_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ROUND_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .clear     (clear),
        .host_we   (host_we),
        .host_addr (host_addr),
        .dp_rst_n  (dp_rst_n),
        .write     (write),
        .calc      (calc),
        .shift     (shift),
        .add_back  (add_back),
        .step      (step),
        .addr_out  (addr_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // m_t: 0 = idle, k = k-th cycle after the start cycle (1..R10+2)
    int   m_t    = 0;
    logic cur_ab = 1'b0;
    bit   chk_en = 1'b1;

    int even_pat[6] = '{1, 2, 2, 3, 3, 3};
    int odd_pat[6]  = '{1, 1, 1, 2, 2, 3};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!rst_n)                       m_t = 0;
        else if (m_t == 0)                m_t = start ? 1 : 0;
        else if (cur_ab && m_t <= R10 + 1) m_t = 0;
        else if (m_t == R10 + 2)          m_t = 0;
        else                              m_t = m_t + 1;
    endtask

    task automatic drive(input logic r, input logic s, input logic c, input logic w,
                         input logic [5:0] a, input logic ab);
        @(posedge clk);
        model_step();
        #1;
        rst_n     = r;
        start     = s;
        clear     = c;
        host_we   = w;
        host_addr = a;
`ifdef ROUND_CTRL_ABORT_EN
        abort  = ab;
        cur_ab = ab;
`else
        cur_ab = 1'b0 & ab;
`endif
        @(negedge clk);
    endtask

    // Compare process: expected outputs derived from the cycle index
    always @(negedge clk) begin
        int  e_calc, e_shift, e_add, e_done, e_busy, e_write, e_dp, e_step, h, r;
        bit  idle;
        if (chk_en) begin
            e_calc = 0; e_shift = 0; e_add = 0; e_done = 0; e_busy = 0;
            e_write = 0; e_dp = 0; e_step = 0;
            if (rst_n) begin
                idle = (m_t == 0);
                if (m_t >= 1 && m_t <= R10) begin
                    h = (m_t - 1) / 10;
                    r = (m_t - 1) % 10;
                    if (r < 4) begin
                        e_calc = 1; e_step = r;
                    end else begin
                        e_shift = 1;
                        e_step  = (h % 2 == 0) ? even_pat[r-4] : odd_pat[r-4];
                    end
                end
                e_add   = (m_t == R10 + 1);
                e_done  = (m_t == R10 + 2);
                e_busy  = (m_t >= 1 && m_t <= R10 + 1);
                e_write = idle && host_we && !start && !clear && !cur_ab;
                e_dp    = !((idle && !start && (clear || cur_ab)) || (e_busy != 0 && cur_ab));
            end
            chk("calc", calc, e_calc);
            chk("shift", shift, e_shift);
            chk("add_back", add_back, e_add);
            chk("done", done, e_done);
            chk("busy", busy, e_busy);
            chk("write", write, e_write);
            chk("dp_rst_n", dp_rst_n, e_dp);
            chk("step", step, e_step);
            chk("addr_out", addr_out, host_addr);
            chk("strobe_excl", ($countones({calc, shift, add_back, write}) <= 1), 1);
        end
    end

    initial begin
        int calc_cnt, shift_cnt, add_at, done_at, sh_n, done_seen;
        int steps[12];
        logic s, c, w, ab, r;

        rst_n = 1'b0; start = 1'b0; clear = 1'b0; host_we = 1'b0; host_addr = '0;
`ifdef ROUND_CTRL_ABORT_EN
        abort = 1'b0;
`endif

        // reset
        drive(0, 0, 0, 0, 6'h00, 0);
        chk("reset_dp_rst_n", dp_rst_n, 0);
        drive(1, 0, 0, 0, 6'h00, 0);
        chk("post_reset_dp_rst_n", dp_rst_n, 1);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_done", done, 0);

        // host write in IDLE
        drive(1, 0, 0, 1, 6'h15, 0);
        chk("host_write", write, 1);
        chk("host_addr", addr_out, 6'h15);

        // start + clear + host_we together: start wins
        drive(1, 1, 1, 1, 6'h2a, 0);
        chk("combo_write", write, 0);
        chk("combo_dp_rst_n", dp_rst_n, 1);

        calc_cnt = 0; shift_cnt = 0; add_at = 0; done_at = 0; sh_n = 0;
        for (int i = 0; i < 12; i++) steps[i] = 0;
        for (int k = 1; k <= 300; k++) begin
            drive(1, 0, 0, 1, 6'($urandom), 0);
            if (k == 5) chk("busy_write", write, 0);
            if (calc) calc_cnt++;
            if (shift) begin
                if (sh_n < 12) steps[sh_n] = step;
                sh_n++;
                shift_cnt++;
            end
            if (add_back) add_at = k;
            if (done) begin
                done_at = k;
                break;
            end
        end
        chk("calc_cycles", calc_cnt, 80);
        chk("shift_cycles", shift_cnt, 120);
        chk("add_back_cycle", add_at, 201);
        chk("done_cycle", done_at, 202);
        for (int i = 0; i < 6; i++) begin
            chk("shift1_step", steps[i], even_pat[i]);
            chk("shift2_step", steps[6+i], odd_pat[i]);
        end

`ifdef ROUND_CTRL_ABORT_EN
        drive(1, 1, 0, 0, 6'h00, 0);
        for (int k = 1; k <= 49; k++) drive(1, 0, 0, 0, 6'h00, 0);
        drive(1, 0, 0, 0, 6'h00, 1);
        chk("abort_dp_rst_n", dp_rst_n, 0);
        chk("abort_busy_c50", busy, 1);
        drive(1, 0, 0, 0, 6'h00, 0);
        chk("abort_idle_c51", busy, 0);
        chk("abort_dp_rst_n_c51", dp_rst_n, 1);
        done_seen = 0;
        for (int k = 0; k < 250; k++) begin
            drive(1, 0, 0, 0, 6'h00, 0);
            if (done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
`else
        done_seen = 0;
`endif

        // randomized traffic
        for (int k = 0; k < 6000; k++) begin
            r  = ($urandom % 700) != 0;
            s  = ($urandom % 20) == 0;
            c  = ($urandom % 8) == 0;
            w  = $urandom % 2;
`ifdef ROUND_CTRL_ABORT_EN
            ab = ($urandom % 150) == 0;
`else
            ab = 1'b0;
`endif
            drive(r, s, c, w, 6'($urandom), ab);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
